step_dir_receiver: RTL and testbench



---
 rtl/steppers_pkg.sv | 37 +++
 rtl/sync_edge_detect.sv | 45 ++++
 rtl/step_dir_receiver.sv | 211 +++++++++++++++++++++
 tb/tb_step_dir_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/steppers_pkg.sv
// steppers_pkg
// Shared definitions for the step/dir receiver and its register bus:
// register offsets, CTRL/STATUS bit positions, position width and the
// packed CTRL layout. No ports.
package steppers_pkg;

  localparam int POS_W = 32;

  localparam logic [7:0] OFF_POS0   = 8'd0;
  localparam logic [7:0] OFF_POS1   = 8'd1;
  localparam logic [7:0] OFF_POS2   = 8'd2;
  localparam logic [7:0] OFF_POS3   = 8'd3;
  localparam logic [7:0] OFF_CTRL   = 8'd4;
  localparam logic [7:0] OFF_STATUS = 8'd5;
  localparam logic [7:0] NUM_REGS   = 8'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_INV  = 1;
  localparam int CTRL_EDGE = 2;
  localparam int CTRL_CLR  = 7;

  localparam int ST_SHORT = 0;
  localparam int ST_DIR   = 1;
  localparam int ST_WRAP  = 2;

  typedef struct packed {
    logic edge_fall;
    logic inv_dir;
    logic enable;
  } ctrl_t;

  // CTRL readback; the clear bit is write-only and always reads 0.
  function automatic logic [7:0] ctrl_to_byte(ctrl_t c);
    return {5'b0, c.edge_fall, c.inv_dir, c.enable};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Multi-flop synchroniser for one asynchronous line followed by an edge
// detector. rise/fall are decoded purely from flop outputs (last sync stage
// and its delayed copy), so they are glitch-free one-cycle pulses, gated by arm.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   arm         : enables rise/fall pulses
//   d_in        : asynchronous input
//   level       : synchronised level
//   rise, fall  : one-cycle edge pulses on the synchronised level
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = arm &  level & ~prev_q;
  assign fall  = arm & ~level &  prev_q;

endmodule

// File: rtl/step_dir_receiver.sv
// step_dir_receiver
// Receiving end of a step/dir link: synchronises step_in/dir_in, counts
// active step edges into a signed position, checks step width and dir
// setup, and exposes position/CTRL/STATUS on an 8-bit register bus.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   rd, wr          : one-cycle CPU strobes
//   cpu_addr        : register address (BASE_ADDR..BASE_ADDR+5)
//   cpu_data_in     : write data
//   cpu_data_out    : registered read data, 0 after an unmatched read
//   step_in, dir_in : asynchronous step/dir lines
//   step_seen       : one-cycle pulse per active step edge
//   error           : OR of the sticky STATUS bits
module step_dir_receiver
  import steppers_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h20,
  parameter int         POS_WIDTH   = POS_W,
  parameter int         SYNC_STAGES = 2,
  parameter int         MIN_PULSE   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_data_in,
  output logic [7:0] cpu_data_out,
  input  logic       step_in,
  input  logic       dir_in,
  output logic       step_seen,
  output logic       error
);

  localparam int CW = $clog2(MIN_PULSE + 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]        MIN_C   = CW'(MIN_PULSE);
  localparam logic [AW-1:0]        ARM_C   = AW'(SYNC_STAGES + 1);
  localparam logic [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

  logic [POS_WIDTH-1:0] pos_q, pos_d, shadow_q, shadow_d;
  logic [23:0]          stage_q, stage_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [2:0]           status_q, status_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 step_seen_q, step_seen_d;
  logic [AW-1:0]        arm_cnt_q, arm_cnt_d;
  logic                 resel_q, resel_d;
  logic [CW-1:0]        width_q, width_d, dir_age_q, dir_age_d;

  logic       armed, step_arm;
  logic       step_lvl, step_rise, step_fall;
  logic       dir_lvl, dir_rise, dir_fall;
  logic [7:0] offset;
  logic       sel;
  logic       act, lead, trail, dir_chg, step_ev;
  logic [2:0] set_bits, clr_bits;
  logic       cpu_pos_wr, wrap_ev;

  // Detectors stay quiet until the synchronisers have flushed after reset,
  // and for one cycle after the active-edge selection changes.
  assign armed    = (arm_cnt_q == '0);
  assign step_arm = armed & ~resel_q;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk   (clk),
    .reset (reset),
    .arm   (step_arm),
    .d_in  (step_in),
    .level (step_lvl),
    .rise  (step_rise),
    .fall  (step_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_dir_sync (
    .clk   (clk),
    .reset (reset),
    .arm   (armed),
    .d_in  (dir_in),
    .level (dir_lvl),
    .rise  (dir_rise),
    .fall  (dir_fall)
  );

  assign offset = cpu_addr - BASE_ADDR;
  assign sel    = (offset < NUM_REGS);

  always_comb begin
    pos_d       = pos_q;
    shadow_d    = shadow_q;
    stage_d     = stage_q;
    ctrl_d      = ctrl_q;
    rdata_d     = rdata_q;
    step_seen_d = 1'b0;
    resel_d     = 1'b0;
    set_bits    = 3'b000;
    clr_bits    = 3'b000;
    cpu_pos_wr  = 1'b0;
    wrap_ev     = 1'b0;

    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q - AW'(1);

    // "Active" means the step line sits at the level that follows the
    // counted edge; the opposite edge ends the pulse.
    act   = step_lvl ^ ctrl_q.edge_fall;
    lead  = ctrl_q.edge_fall ? step_fall : step_rise;
    trail = ctrl_q.edge_fall ? step_rise : step_fall;

    width_d = act ? ((width_q == MIN_C) ? width_q : width_q + CW'(1)) : '0;

    // dir_age counts cycles since the last synced dir change, saturating.
    dir_chg   = dir_rise | dir_fall;
    dir_age_d = dir_chg ? CW'(1) : ((dir_age_q == MIN_C) ? dir_age_q : dir_age_q + CW'(1));

    step_ev = lead & ctrl_q.enable;
    if (step_ev) begin
      step_seen_d = 1'b1;
      if (dir_lvl ^ ctrl_q.inv_dir) begin
        pos_d   = pos_q + POS_WIDTH'(1);
        wrap_ev = (pos_q == POS_MAX);
      end else begin
        pos_d   = pos_q - POS_WIDTH'(1);
        wrap_ev = (pos_q == POS_MIN);
      end
      if (dir_chg || (dir_age_q < MIN_C)) set_bits[ST_DIR] = 1'b1;
    end
    if (trail && ctrl_q.enable && (width_q < MIN_C)) set_bits[ST_SHORT] = 1'b1;

    if (rd) begin
      rdata_d = 8'h00;
      if (sel) begin
        case (offset)
          OFF_POS0: begin
            rdata_d  = pos_q[7:0];
            shadow_d = pos_q;
          end
          OFF_POS1:   rdata_d = shadow_q[15:8];
          OFF_POS2:   rdata_d = shadow_q[23:16];
          OFF_POS3:   rdata_d = shadow_q[31:24];
          OFF_CTRL:   rdata_d = ctrl_to_byte(ctrl_q);
          OFF_STATUS: rdata_d = {5'b0, status_q};
          default:    rdata_d = 8'h00;
        endcase
      end
    end

    // CPU writes to position are applied last so they override a step.
    if (wr && sel) begin
      case (offset)
        OFF_POS0: stage_d[7:0]   = cpu_data_in;
        OFF_POS1: stage_d[15:8]  = cpu_data_in;
        OFF_POS2: stage_d[23:16] = cpu_data_in;
        OFF_POS3: begin
          pos_d      = {cpu_data_in, stage_q};
          cpu_pos_wr = 1'b1;
        end
        OFF_CTRL: begin
          ctrl_d.enable    = cpu_data_in[CTRL_EN];
          ctrl_d.inv_dir   = cpu_data_in[CTRL_INV];
          ctrl_d.edge_fall = cpu_data_in[CTRL_EDGE];
          resel_d          = cpu_data_in[CTRL_EDGE] ^ ctrl_q.edge_fall;
          if (cpu_data_in[CTRL_CLR]) begin
            pos_d      = '0;
            cpu_pos_wr = 1'b1;
          end
        end
        OFF_STATUS: clr_bits = cpu_data_in[2:0];
        default: ;
      endcase
    end

    // A discarded step cannot wrap the position.
    if (wrap_ev && !cpu_pos_wr) set_bits[ST_WRAP] = 1'b1;

    status_d = (status_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q       <= '0;
      shadow_q    <= '0;
      stage_q     <= '0;
      ctrl_q      <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      step_seen_q <= 1'b0;
      arm_cnt_q   <= ARM_C;
      resel_q     <= 1'b0;
      width_q     <= '0;
      dir_age_q   <= MIN_C;
    end else begin
      pos_q       <= pos_d;
      shadow_q    <= shadow_d;
      stage_q     <= stage_d;
      ctrl_q      <= ctrl_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      step_seen_q <= step_seen_d;
      arm_cnt_q   <= arm_cnt_d;
      resel_q     <= resel_d;
      width_q     <= width_d;
      dir_age_q   <= dir_age_d;
    end
  end

  assign cpu_data_out = rdata_q;
  assign step_seen    = step_seen_q;
  assign error        = |status_q;

endmodule

// File: tb/tb_step_dir_receiver.sv
module tb_step_dir_receiver;

  localparam logic [7:0] BASE = 8'h20;
  localparam int         MINP = 4;

  logic       clk = 1'b0;
  logic       reset, rd, wr;
  logic [7:0] cpu_addr, cpu_data_in, cpu_data_out;
  logic       step_in, dir_in, step_seen, error;

  int tests = 0;
  int fails = 0;
  int seen_cnt = 0;

  // Reference model state
  logic [31:0] m_pos;
  logic [2:0]  m_st;
  bit          m_en, m_inv, m_fall;

  step_dir_receiver #(
    .BASE_ADDR(BASE), .POS_WIDTH(32), .SYNC_STAGES(2), .MIN_PULSE(MINP)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .step_in(step_in), .dir_in(dir_in), .step_seen(step_seen), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step_seen === 1'b1) seen_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [7:0] data);
    cpu_addr = BASE + off; cpu_data_in = data; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [7:0] data);
    cpu_addr = BASE + off; rd = 1'b1;
    tick(1);
    rd = 1'b0;
    data = cpu_data_out;
  endtask

  task automatic read_pos(output logic [31:0] p);
    logic [7:0] b;
    bus_read(8'd0, b); p[7:0]   = b;
    bus_read(8'd1, b); p[15:8]  = b;
    bus_read(8'd2, b); p[23:16] = b;
    bus_read(8'd3, b); p[31:24] = b;
  endtask

  task automatic write_pos(input logic [31:0] p);
    bus_write(8'd0, p[7:0]);
    bus_write(8'd1, p[15:8]);
    bus_write(8'd2, p[23:16]);
    bus_write(8'd3, p[31:24]);
    m_pos = p;
  endtask

  task automatic set_ctrl(input bit en, input bit inv, input bit fall);
    bus_write(8'd4, {5'b0, fall, inv, en});
    m_en = en; m_inv = inv; m_fall = fall;
    tick(2);
  endtask

  task automatic st_clear(input logic [2:0] mask);
    bus_write(8'd5, {5'b0, mask});
    m_st = m_st & ~mask;
  endtask

  // One counted step: signed position moves by +/-1, overflow past the
  // 32-bit signed range wraps and flags STATUS2.
  task automatic m_step(input bit pin_dir);
    longint cur, nxt;
    if (!m_en) return;
    cur = longint'($signed(m_pos));
    nxt = cur + (((pin_dir ^ m_inv) != 0) ? 64'sd1 : -64'sd1);
    if (nxt > 64'sd2147483647 || nxt < -64'sd2147483648) m_st[2] = 1'b1;
    m_pos = 32'(nxt);
  endtask

  // Positive pulse on step_in (idle low). In rising mode a high time
  // shorter than MIN_PULSE is a short pulse.
  task automatic pulse(input int width, input int gap);
    step_in = 1'b1; tick(width);
    step_in = 1'b0; tick(gap);
    if (m_en && !m_fall && width < MINP) m_st[0] = 1'b1;
    m_step(dir_in);
  endtask

  task automatic dir_then_pulse(input int lead);
    dir_in = ~dir_in;
    tick(lead);
    pulse(8, 8);
    if (m_en && lead < MINP) m_st[1] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] p;
    logic [7:0]  b;
    read_pos(p);
    check({tag, "_pos"}, p, m_pos);
    bus_read(8'd5, b);
    check({tag, "_status"}, 32'(b), 32'(m_st));
    check({tag, "_error"}, 32'(error), 32'(|m_st));
  endtask

  initial begin
    logic [7:0] b;
    int s0;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; cpu_addr = '0; cpu_data_in = '0;
    step_in = 1'b0; dir_in = 1'b0;
    m_pos = '0; m_st = '0; m_en = 0; m_inv = 0; m_fall = 0;

    tick(3);
    check("rst_dout", 32'(cpu_data_out), 32'h0);
    check("rst_seen", 32'(step_seen), 32'h0);
    check("rst_err", 32'(error), 32'h0);
    reset = 1'b0;
    tick(4);
    check_all("reset");
    bus_read(8'd4, b);
    check("rst_ctrl", 32'(b), 32'h0);

    // Basic counting
    dir_in = 1'b1;
    set_ctrl(1, 0, 0);
    tick(4);
    s0 = seen_cnt;
    repeat (10) pulse(8, 8);
    tick(4);
    check("seen10", 32'(seen_cnt - s0), 32'd10);
    check_all("count10");

    // Wrap and W1C
    write_pos(32'h7FFF_FFFF);
    check_all("preset_max");
    pulse(8, 8);
    check_all("wrap");
    st_clear(3'b100);
    check_all("wrap_clr");

    // Width boundary and short pulse
    pulse(4, 8);
    check_all("width4");
    pulse(2, 8);
    check_all("short");
    st_clear(3'b001);

    // Dir setup boundary and violation
    dir_then_pulse(4);
    check_all("dir_lead4");
    dir_then_pulse(1);
    check_all("dir_lead1");
    st_clear(3'b010);
    tick(6);

    // Shadow
    write_pos(32'h0000_01FF);
    bus_read(8'd0, b);
    check("pos0_live", 32'(b), 32'h0000_00FF);
    repeat (5) pulse(8, 8);
    bus_read(8'd1, b);
    check("pos1_shadow", 32'(b), 32'h0000_0001);
    check_all("after_shadow");

    // CPU commit coincides with the counted edge
    bus_write(8'd0, 8'h00); bus_write(8'd1, 8'h10); bus_write(8'd2, 8'h00);
    s0 = seen_cnt;
    step_in = 1'b1;
    tick(2);
    bus_write(8'd3, 8'h00);
    tick(5);
    step_in = 1'b0;
    tick(8);
    m_pos = 32'h0000_1000;
    check("commit_seen", 32'(seen_cnt - s0), 32'd1);
    check_all("commit");

    // Reset mid-operation, step held high across release
    pulse(2, 8);
    check("pre_rst_err", 32'(error), 32'h1);
    bus_read(8'd4, b);
    check("pre_rst_ctrl", 32'(b), 32'h1);
    step_in = 1'b1;
    reset = 1'b1;
    tick(1);
    check("midrst_dout", 32'(cpu_data_out), 32'h0);
    check("midrst_err", 32'(error), 32'h0);
    tick(2);
    reset = 1'b0;
    m_pos = '0; m_st = '0; m_en = 0; m_inv = 0; m_fall = 0;
    s0 = seen_cnt;
    bus_write(8'd4, 8'h01);
    m_en = 1;
    tick(8);
    step_in = 1'b0;
    tick(8);
    check("rel_high_seen", 32'(seen_cnt - s0), 32'd0);
    check_all("rel_high");

    // Disabled
    set_ctrl(0, 0, 0);
    s0 = seen_cnt;
    repeat (20) pulse(8, 6);
    check("dis_seen", 32'(seen_cnt - s0), 32'd0);
    check_all("disabled");

    // Falling edge only
    set_ctrl(1, 0, 1);
    s0 = seen_cnt;
    step_in = 1'b1; tick(6);
    check("fall_norise", 32'(seen_cnt - s0), 32'd0);
    step_in = 1'b0; tick(6);
    check("fall_count", 32'(seen_cnt - s0), 32'd1);
    m_step(dir_in);
    repeat (4) pulse(8, 8);
    check("fall_seen5", 32'(seen_cnt - s0), 32'd5);
    check_all("falling");

    // Inverted direction
    set_ctrl(1, 1, 0);
    repeat (7) pulse(8, 8);
    check_all("invert");

    // Randomised rounds
    for (int r = 0; r < 4; r++) begin
      set_ctrl($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      s0 = seen_cnt;
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 1) != 0) begin
          dir_in = ~dir_in;
          tick(6);
        end
        pulse(int'($urandom_range(4, 10)), int'($urandom_range(4, 10)));
      end
      tick(4);
      check($sformatf("rnd%0d_seen", r), 32'(seen_cnt - s0), m_en ? 32'd10 : 32'd0);
      check_all($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
